// File: rtl/core_acc_collect.sv
// core_acc_collect: packs accumulator results into wide words and queues them in a small FIFO.
// Define CORE_ACC_COLLECT_RELU_EN to clamp negative lanes to zero before packing.
module core_acc_collect #(
  parameter int IDATA_BIT = 32,
  parameter int PACK_NUM = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(PACK_NUM):0]     cfg_pack_num,
  input  logic [IDATA_BIT-1:0]          idata,
  input  logic                          idata_valid,
  input  logic                          flush,
  output logic [IDATA_BIT*PACK_NUM-1:0] odata,
  output logic [PACK_NUM-1:0]           odata_keep,
  output logic                          odata_valid,
  input  logic                          odata_ready,
  output logic                          overflow,
  output logic                          busy
);
  localparam int LW = $clog2(PACK_NUM);
  localparam int CW = LW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = IDATA_BIT * PACK_NUM;
  logic [LW-1:0] lane_cnt;
  logic [CW-1:0] eff_pack, cfg_eff;
  logic [OW-1:0] word, word_nxt;
  logic [PACK_NUM-1:0] keep, keep_nxt;
  logic [IDATA_BIT-1:0] lane_in;
  logic complete, push, pop, full, empty, wr;
  logic [AW:0] wptr, rptr;
  logic [OW-1:0] mem_d [FIFO_DEPTH];
  logic [PACK_NUM-1:0] mem_k [FIFO_DEPTH];
`ifdef CORE_ACC_COLLECT_RELU_EN
  assign lane_in = idata[IDATA_BIT-1] ? '0 : idata;
`else
  assign lane_in = idata;
`endif
  assign cfg_eff = (cfg_pack_num == '0 || cfg_pack_num > CW'(PACK_NUM)) ? CW'(PACK_NUM) : cfg_pack_num;
  for (genvar i = 0; i < PACK_NUM; i++) begin : g_lane
    logic sel;
    assign sel = idata_valid && lane_cnt == LW'(i);
    assign word_nxt[i*IDATA_BIT +: IDATA_BIT] = sel ? lane_in : word[i*IDATA_BIT +: IDATA_BIT];
    assign keep_nxt[i] = sel | keep[i];
  end
  assign complete = idata_valid && {1'b0, lane_cnt} == eff_pack - CW'(1);
  assign push = complete || (flush && (lane_cnt != '0 || idata_valid));
  assign empty = wptr == rptr;
  assign full = wptr == {~rptr[AW], rptr[AW-1:0]};
  assign odata_valid = !empty;
  assign pop = odata_valid && odata_ready;
  // a pop frees the head slot on the same edge, so a full FIFO still accepts
  assign wr = push && (!full || pop);
  assign odata = empty ? '0 : mem_d[rptr[AW-1:0]];
  assign odata_keep = empty ? '0 : mem_k[rptr[AW-1:0]];
  assign busy = lane_cnt != '0 || !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      word <= '0;
      keep <= '0;
      eff_pack <= CW'(PACK_NUM);
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
    end else begin
      lane_cnt <= push ? '0 : idata_valid ? lane_cnt + LW'(1) : lane_cnt;
      word <= push ? '0 : word_nxt;
      keep <= push ? '0 : keep_nxt;
      if (lane_cnt == '0 && !idata_valid) eff_pack <= cfg_eff;
      if (wr) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_d[wptr[AW-1:0]] <= word_nxt;
      mem_k[wptr[AW-1:0]] <= keep_nxt;
    end
  end
endmodule

// File: tb/tb_core_acc_collect.sv
// tb_core_acc_collect: random and directed stimulus scored against a queue-based model of the collector.
module tb_core_acc_collect;
  localparam int W = 32;
  localparam int P = 4;
  localparam int D = 4;
  logic clk = 0;
  logic rst;
  logic [2:0] cfg_pack_num;
  logic [W-1:0] idata;
  logic idata_valid, flush, odata_ready;
  logic [W*P-1:0] odata;
  logic [P-1:0] odata_keep;
  logic odata_valid, overflow, busy;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] lanes [$];
  logic [W*P-1:0] qd [$];
  logic [P-1:0] qk [$];
  int eff = P;
  bit ovf_exp = 0;

  core_acc_collect #(.IDATA_BIT(W), .PACK_NUM(P), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cfg_pack_num(cfg_pack_num), .idata(idata),
    .idata_valid(idata_valid), .flush(flush), .odata(odata), .odata_keep(odata_keep),
    .odata_valid(odata_valid), .odata_ready(odata_ready), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] relu(input logic [W-1:0] x);
`ifdef CORE_ACC_COLLECT_RELU_EN
    return $signed(x) < 0 ? '0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string n, input logic [W*P-1:0] a, input logic [W*P-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  // reference model: lanes queue for the packer, word queue for the FIFO
  initial forever begin
    bit was_empty;
    logic [W*P-1:0] w;
    logic [P-1:0] k;
    @(posedge clk);
    if (rst) begin
      lanes.delete(); qd.delete(); qk.delete();
      ovf_exp = 0;
      eff = P;
    end else begin
      was_empty = lanes.size() == 0;
      if (idata_valid) lanes.push_back(relu(idata));
      if ((idata_valid && lanes.size() == eff) || (flush && lanes.size() > 0)) begin
        w = '0;
        k = '0;
        foreach (lanes[i]) begin
          w[i*W +: W] = lanes[i];
          k[i] = 1'b1;
        end
        lanes.delete();
        if (qd.size() < D) begin
          qd.push_back(w);
          qk.push_back(k);
        end else ovf_exp = 1;
      end
      if (was_empty && !idata_valid) eff = (cfg_pack_num == 0 || cfg_pack_num > P) ? P : int'(cfg_pack_num);
    end
  end

  // monitor: compares outputs mid-cycle and retires the head on a handshake
  initial forever begin
    @(negedge clk);
    chk("valid", W*P'(odata_valid), W*P'(qd.size() != 0));
    chk("busy", W*P'(busy), W*P'(lanes.size() != 0 || qd.size() != 0));
    chk("overflow", W*P'(overflow), W*P'(ovf_exp));
    if (odata_valid && qd.size() != 0) begin
      chk("odata", odata, qd[0]);
      chk("keep", W*P'(odata_keep), W*P'(qk[0]));
      if (odata_ready && !rst) begin
        void'(qd.pop_front());
        void'(qk.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic beat(input logic [W-1:0] d);
    idata_valid = 1; idata = d;
    @(posedge clk); #2;
    idata_valid = 0;
  endtask
  task automatic do_flush();
    flush = 1;
    @(posedge clk); #2;
    flush = 0;
  endtask
  task automatic reset_dut();
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
  endtask

  initial begin
    rst = 1; cfg_pack_num = 4; idata = 0; idata_valid = 0; flush = 0; odata_ready = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("rst_odata", odata, '0);
    chk("rst_keep", W*P'(odata_keep), '0);
    chk("rst_valid", W*P'(odata_valid), '0);
    @(posedge clk); #2;
    for (int i = 1; i <= 4; i++) beat(i);
    idle(2);
    beat(10); beat(20); do_flush(); idle(2); do_flush(); idle(2);
    cfg_pack_num = 2; odata_ready = 0; idle(1);
    for (int i = 0; i < 8; i++) beat(i);
    beat(100);
    odata_ready = 1; beat(101); odata_ready = 0;
    idle(3); odata_ready = 1; idle(8);
    odata_ready = 0;
    for (int i = 0; i < 10; i++) beat(i);
    idle(4); odata_ready = 1; idle(8);
    reset_dut();
    cfg_pack_num = 4; idle(1);
    beat(1); cfg_pack_num = 2;
    beat(2); beat(3); beat(4); beat(5); beat(6); idle(3);
    odata_ready = 0;
    for (int i = 0; i < 6; i++) beat(i + 50);
    reset_dut(); idle(2);
    odata_ready = 1; cfg_pack_num = 2; idle(1);
    beat(-5); beat(7); idle(3);
    for (int c = 0; c < 4000; c++) begin
      idata_valid = $urandom_range(0, 2) != 0;
      idata = $urandom;
      flush = $urandom_range(0, 9) == 0;
      odata_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 49) == 0) cfg_pack_num = 3'($urandom_range(0, 7));
      rst = $urandom_range(0, 299) == 0;
      @(posedge clk); #2;
    end
    idata_valid = 0; flush = 0; rst = 0; odata_ready = 1;
    do_flush(); idle(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
